// File: rtl/fabric_cfg_loader.sv
// Loads a byte-serial frame stream (CMD, OFF, LEN, data) into the fabric configuration vectors.
// One byte per accepted cycle; in_ready drops only for the single DONE cycle after each frame.
`timescale 1ns/1ps
module fabric_cfg_loader #(
   parameter int wire_width  = 7,
   parameter int lb_cfg_size = 18,
   parameter int fpga_width  = 5,
   parameter int fpga_height = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic [7:0] in_data,
   input  logic in_valid,
   output logic in_ready,
   output logic [fpga_height*fpga_width*wire_width*12-1:0] brbselect,
   output logic [(fpga_height-1)*(fpga_width-1)*wire_width*wire_width*12-1:0] bsbselect,
   output logic [fpga_width*fpga_height*lb_cfg_size-1:0] lbselect,
   output logic [2*wire_width*fpga_height-1:0] leftioselect,
   output logic [2*wire_width*fpga_height-1:0] rightioselect,
   output logic [2*wire_width*fpga_height-1:0] topioselect,
   output logic [2*wire_width*fpga_height-1:0] bottomioselect,
   output logic busy,
   output logic frame_done,
   output logic err
);
   localparam int BRB_W  = fpga_height*fpga_width*wire_width*12;
   localparam int BSB_W  = (fpga_height-1)*(fpga_width-1)*wire_width*wire_width*12;
   localparam int LB_W   = fpga_width*fpga_height*lb_cfg_size;
   localparam int IO_W   = 2*wire_width*fpga_height;
   localparam int BRB_AW = $clog2(BRB_W);
   localparam int BSB_AW = $clog2(BSB_W);
   localparam int LB_AW  = $clog2(LB_W);
   localparam int IO_AW  = $clog2(IO_W);

   typedef enum logic [2:0] {
      S_IDLE, S_OFF_LO, S_OFF_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE
   } state_t;

   state_t r_state, w_state_nxt;
   logic [2:0]  r_tgt;
   logic [15:0] r_off;
   logic [15:0] r_len;
   logic [16:0] r_cnt;
   logic        r_bad;
   logic        r_err;

   logic [BRB_W-1:0] r_brb;
   logic [BSB_W-1:0] r_bsb;
   logic [LB_W-1:0]  r_lb;
   logic [IO_W-1:0]  r_left, r_right, r_top, r_bottom;

   logic        w_acc;
   logic [15:0] w_len_full;
   logic [16:0] w_end;
   logic [16:0] w_tgt_w;
   logic        w_bad_now;
   logic        w_last;
   logic [7:0]  w_bit_en;
   logic [16:0] w_pos [8];

   assign w_acc      = in_valid && in_ready;
   assign w_len_full = {in_data, r_len[7:0]};
   assign w_end      = {1'b0, r_off} + {1'b0, w_len_full};
   assign w_bad_now  = (r_tgt == 3'd7) || (w_end > w_tgt_w);
   assign w_last     = (r_cnt + 17'd8) >= {1'b0, r_len};

   always_comb begin
      w_tgt_w = 17'd0;
      case (r_tgt)
         3'd0:    w_tgt_w = 17'(BRB_W);
         3'd1:    w_tgt_w = 17'(BSB_W);
         3'd2:    w_tgt_w = 17'(LB_W);
         3'd3, 3'd4, 3'd5, 3'd6: w_tgt_w = 17'(IO_W);
         default: w_tgt_w = 17'd0;
      endcase
   end

   // Per-bit enable and absolute region position for the byte being accepted.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_bit_en[i] = (r_cnt + 17'(i)) < {1'b0, r_len};
         w_pos[i]    = {1'b0, r_off} + r_cnt + 17'(i);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_acc) w_state_nxt = S_OFF_LO;
         S_OFF_LO: if (w_acc) w_state_nxt = S_OFF_HI;
         S_OFF_HI: if (w_acc) w_state_nxt = S_LEN_LO;
         S_LEN_LO: if (w_acc) w_state_nxt = S_LEN_HI;
         S_LEN_HI: if (w_acc) w_state_nxt = (w_len_full == 16'd0) ? S_DONE : S_DATA;
         S_DATA:   if (w_acc && w_last) w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tgt <= 3'd0;
         r_off <= 16'd0;
         r_len <= 16'd0;
         r_cnt <= 17'd0;
         r_bad <= 1'b0;
         r_err <= 1'b0;
      end else if (w_acc) begin
         case (r_state)
            S_IDLE:   r_tgt <= in_data[2:0];
            S_OFF_LO: r_off[7:0]  <= in_data;
            S_OFF_HI: r_off[15:8] <= in_data;
            S_LEN_LO: r_len[7:0]  <= in_data;
            S_LEN_HI: begin
               r_len[15:8] <= in_data;
               r_cnt       <= 17'd0;
               r_bad       <= w_bad_now;
               if (w_bad_now) r_err <= 1'b1;
            end
            S_DATA:   r_cnt <= r_cnt + 17'd8;
            default:  ;
         endcase
      end
   end

   // Bad frames still walk the data phase, but r_bad blocks every write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_brb    <= '0;
         r_bsb    <= '0;
         r_lb     <= '0;
         r_left   <= '0;
         r_right  <= '0;
         r_top    <= '0;
         r_bottom <= '0;
      end else if (w_acc && (r_state == S_DATA) && !r_bad) begin
         for (int i = 0; i < 8; i++) begin
            if (w_bit_en[i] && (w_pos[i] < w_tgt_w)) begin
               case (r_tgt)
                  3'd0:    r_brb[w_pos[i][BRB_AW-1:0]]   <= in_data[i];
                  3'd1:    r_bsb[w_pos[i][BSB_AW-1:0]]   <= in_data[i];
                  3'd2:    r_lb[w_pos[i][LB_AW-1:0]]     <= in_data[i];
                  3'd3:    r_left[w_pos[i][IO_AW-1:0]]   <= in_data[i];
                  3'd4:    r_right[w_pos[i][IO_AW-1:0]]  <= in_data[i];
                  3'd5:    r_top[w_pos[i][IO_AW-1:0]]    <= in_data[i];
                  3'd6:    r_bottom[w_pos[i][IO_AW-1:0]] <= in_data[i];
                  default: ;
               endcase
            end
         end
      end
   end

   assign in_ready       = !rst && (r_state != S_DONE);
   assign busy           = (r_state != S_IDLE);
   assign frame_done     = (r_state == S_DONE);
   assign err            = r_err;
   assign brbselect      = r_brb;
   assign bsbselect      = r_bsb;
   assign lbselect       = r_lb;
   assign leftioselect   = r_left;
   assign rightioselect  = r_right;
   assign topioselect    = r_top;
   assign bottomioselect = r_bottom;
endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Bench for fabric_cfg_loader: directed frames plus randomized frames checked against a bit-array model.
`timescale 1ns/1ps
module tb_fabric_cfg_loader;
   localparam int BRB_W = 5*5*7*12;
   localparam int BSB_W = 4*4*7*7*12;
   localparam int LB_W  = 5*5*18;
   localparam int IO_W  = 2*7*5;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] in_data;
   logic in_valid;
   logic in_ready;
   logic [BRB_W-1:0] brbselect;
   logic [BSB_W-1:0] bsbselect;
   logic [LB_W-1:0]  lbselect;
   logic [IO_W-1:0]  leftioselect, rightioselect, topioselect, bottomioselect;
   logic busy, frame_done, err;

   fabric_cfg_loader #(.wire_width(7), .lb_cfg_size(18), .fpga_width(5), .fpga_height(5)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .brbselect(brbselect), .bsbselect(bsbselect), .lbselect(lbselect),
      .leftioselect(leftioselect), .rightioselect(rightioselect),
      .topioselect(topioselect), .bottomioselect(bottomioselect),
      .busy(busy), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int g_wait;
   int g_first_wait;

   // Model: one zero-padded bit array per target region, plus the sticky error.
   logic [BSB_W-1:0] m_vec [7];
   int               m_w   [7];
   logic             m_err;

   function automatic logic [BSB_W-1:0] dut_vec(input int t);
      case (t)
         0: return BSB_W'(brbselect);
         1: return bsbselect;
         2: return BSB_W'(lbselect);
         3: return BSB_W'(leftioselect);
         4: return BSB_W'(rightioselect);
         5: return BSB_W'(topioselect);
         6: return BSB_W'(bottomioselect);
         default: return '0;
      endcase
   endfunction

   function automatic int diff_bit(output int vi, output logic got, output logic want);
      logic [BSB_W-1:0] d;
      vi = -1; got = 1'b0; want = 1'b0;
      for (int t = 0; t < 7; t++) begin
         d = dut_vec(t);
         if (d !== m_vec[t]) begin
            for (int b = 0; b < BSB_W; b++) begin
               if (d[b] !== m_vec[t][b]) begin
                  vi = t; got = d[b]; want = m_vec[t][b];
                  return b;
               end
            end
         end
      end
      return -1;
   endfunction

   task automatic model_clear();
      for (int t = 0; t < 7; t++) m_vec[t] = '0;
      m_err = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_stall);
      int n;
      n = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      repeat (n) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = b;
      g_wait   = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         g_wait++;
         if (g_wait > 20) begin
            total++; bad++;
            $display("FAIL accept_timeout byte=%02h got=no_accept want=accept", b);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [15:0] off, input logic [15:0] len,
                             input logic [7:0] data [$], input int stall);
      int t;
      send_byte(cmd, stall);
      g_first_wait = g_wait;
      send_byte(off[7:0], stall);
      send_byte(off[15:8], stall);
      send_byte(len[7:0], stall);
      send_byte(len[15:8], stall);
      foreach (data[k]) send_byte(data[k], stall);
      t = int'(cmd[2:0]);
      if (t == 7) m_err = 1'b1;
      else if (int'(off) + int'(len) > m_w[t]) m_err = 1'b1;
      else for (int j = 0; j < int'(len); j++) m_vec[t][int'(off) + j] = data[j/8][j%8];
   endtask

   task automatic test_reset();
      int vi, vb; logic g, e;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      model_clear();
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      total++; if (busy !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL reset_flags got=%b%b%b want=000", busy, frame_done, err); end
      vb = diff_bit(vi, g, e);
      total++; if (vb >= 0) begin bad++; $display("FAIL reset_vectors vec%0d bit%0d got=%b want=%b", vi, vb, g, e); end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_single();
      int vi, vb; logic g, e;
      logic [7:0] q [$];
      q = {8'h01};
      send_frame(8'h00, 16'd5, 16'd1, q, 0);
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL single_done got=%b want=1", frame_done); end
      total++; if (brbselect[5] !== 1'b1) begin bad++; $display("FAIL single_brb5 got=%b want=1", brbselect[5]); end
      vb = diff_bit(vi, g, e);
      total++; if (vb >= 0) begin bad++; $display("FAIL single_vectors vec%0d bit%0d got=%b want=%b", vi, vb, g, e); end
      @(posedge clk); #1;
      total++; if (frame_done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL single_after done/busy/err got=%b%b%b want=000", frame_done, busy, err); end
   endtask

   task automatic test_back_to_back();
      int vi, vb; logic g, e;
      logic [7:0] q [$];
      q = {8'h01};
      send_frame(8'h06, 16'd1, 16'd1, q, 0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_done_ready got=%b want=0", in_ready); end
      send_frame(8'h03, 16'd0, 16'd1, q, 0);
      total++; if (g_first_wait !== 1) begin bad++; $display("FAIL b2b_gap got=%0d want=1", g_first_wait); end
      total++; if (bottomioselect[1] !== 1'b1 || leftioselect[0] !== 1'b1) begin
         bad++; $display("FAIL b2b_bits got=%b%b want=11", bottomioselect[1], leftioselect[0]); end
      vb = diff_bit(vi, g, e);
      total++; if (vb >= 0) begin bad++; $display("FAIL b2b_vectors vec%0d bit%0d got=%b want=%b", vi, vb, g, e); end
   endtask

   task automatic test_stalls();
      int vi, vb; logic g, e;
      logic [7:0] q [$];
      q = {8'hA5, 8'h07};
      send_frame(8'h02, 16'd3, 16'd11, q, 3);
      total++; if (lbselect[13:3] !== 11'b111_1010_0101) begin
         bad++; $display("FAIL stall_lb_run got=%b want=11110100101", lbselect[13:3]); end
      total++; if (lbselect[14] !== 1'b0 || lbselect[2:0] !== 3'b000) begin
         bad++; $display("FAIL stall_lb_edges got=%b_%b want=0_000", lbselect[14], lbselect[2:0]); end
      vb = diff_bit(vi, g, e);
      total++; if (vb >= 0) begin bad++; $display("FAIL stall_vectors vec%0d bit%0d got=%b want=%b", vi, vb, g, e); end
   endtask

   task automatic test_len_zero();
      int vi, vb; logic g, e;
      logic [7:0] q [$];
      q = {};
      send_frame(8'h04, 16'h0010, 16'd0, q, 0);
      total++; if (frame_done !== 1'b1 || err !== 1'b0) begin
         bad++; $display("FAIL len0_done/err got=%b%b want=10", frame_done, err); end
      vb = diff_bit(vi, g, e);
      total++; if (vb >= 0) begin bad++; $display("FAIL len0_vectors vec%0d bit%0d got=%b want=%b", vi, vb, g, e); end
      send_frame(8'h07, 16'd0, 16'd0, q, 0);
      total++; if (frame_done !== 1'b1 || err !== 1'b1) begin
         bad++; $display("FAIL cmd7_done/err got=%b%b want=11", frame_done, err); end
   endtask

   task automatic test_mid_reset();
      int vi, vb; logic g, e;
      logic [7:0] q [$];
      send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'hFF, 0);
      total++; if (busy !== 1'b1 || brbselect[7:0] !== 8'hFF) begin
         bad++; $display("FAIL midrst_pre busy/brb got=%b/%02h want=1/ff", busy, brbselect[7:0]); end
      rst = 1'b1;
      #1;
      model_clear();
      total++; if (busy !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL midrst_flags busy/err/rdy got=%b%b%b want=000", busy, err, in_ready); end
      vb = diff_bit(vi, g, e);
      total++; if (vb >= 0) begin bad++; $display("FAIL midrst_clear vec%0d bit%0d got=%b want=%b", vi, vb, g, e); end
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      q = {8'h05};
      send_frame(8'h00, 16'd2, 16'd3, q, 1);
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL midrst_newframe got=%b want=1", frame_done); end
      vb = diff_bit(vi, g, e);
      total++; if (vb >= 0) begin bad++; $display("FAIL midrst_vectors vec%0d bit%0d got=%b want=%b", vi, vb, g, e); end
   endtask

   task automatic test_bad_frame();
      int vi, vb; logic g, e;
      logic [7:0] q [$];
      send_byte(8'h01, 0); send_byte(8'hFE, 0); send_byte(8'h24, 0);
      send_byte(8'h0A, 0); send_byte(8'h00, 0);
      total++; if (err !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL bad_err_at_len err/busy got=%b%b want=11", err, busy); end
      send_byte(8'hFF, 0);
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL bad_consume1 done got=%b want=0", frame_done); end
      send_byte(8'hFF, 0);
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bad_consume2 done got=%b want=1", frame_done); end
      m_err = 1'b1;
      vb = diff_bit(vi, g, e);
      total++; if (vb >= 0) begin bad++; $display("FAIL bad_vectors vec%0d bit%0d got=%b want=%b", vi, vb, g, e); end
      q = {8'h0A};
      send_frame(8'h05, 16'd3, 16'd4, q, 0);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_sticky err got=%b want=1", err); end
      vb = diff_bit(vi, g, e);
      total++; if (vb >= 0) begin bad++; $display("FAIL bad_follow vec%0d bit%0d got=%b want=%b", vi, vb, g, e); end
   endtask

   task automatic test_random();
      int vi, vb; logic g, e;
      int t, off, len, maxl, nb;
      logic [7:0] q [$];
      rst = 1'b1;
      #1 model_clear();
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      for (int f = 0; f < 30; f++) begin
         t = int'($urandom_range(0, 7));
         if (t == 7) begin
            off = int'($urandom_range(0, 100));
            len = int'($urandom_range(0, 20));
         end else begin
            off  = int'($urandom_range(0, m_w[t] - 1));
            maxl = m_w[t] - off;
            if (maxl > 40) maxl = 40;
            len = int'($urandom_range(0, maxl));
            if ($urandom_range(0, 5) == 0) len = maxl + int'($urandom_range(1, 10));
         end
         nb = (len + 7) / 8;
         q = {};
         for (int k = 0; k < nb; k++) q.push_back(8'($urandom));
         send_frame({5'($urandom), 3'(t)}, 16'(off), 16'(len), q, 2);
         total++; if (frame_done !== 1'b1 || err !== m_err) begin
            bad++; $display("FAIL rand%0d done/err got=%b%b want=1%b", f, frame_done, err, m_err); end
         vb = diff_bit(vi, g, e);
         total++; if (vb >= 0) begin
            bad++; $display("FAIL rand%0d_vectors vec%0d bit%0d got=%b want=%b", f, vi, vb, g, e); end
      end
   endtask

   initial begin
      m_w = '{BRB_W, BSB_W, LB_W, IO_W, IO_W, IO_W, IO_W};
      test_reset();
      test_single();
      test_back_to_back();
      test_stalls();
      test_len_zero();
      test_mid_reset();
      test_bad_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule
